// File: rtl/booth_pkg.sv
// booth_pkg: shared widths, FSM state encoding and saturation helper for booth_mac
package booth_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Clamp v into the signed range of a w-bit value (w < 64).
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/booth1.sv
// booth1: combinational 8x8 signed radix-2 Booth multiplier
module booth1
    import booth_pkg::*;
(
    input  logic [OP_W-1:0]   multiplier,
    input  logic [OP_W-1:0]   multiplicand,
    output logic [PROD_W-1:0] product
);

    logic [PROD_W-1:0] m_ext;
    logic [OP_W:0]     q;

    assign m_ext = {{(PROD_W-OP_W){multiplicand[OP_W-1]}}, multiplicand};
    assign q     = {multiplier, 1'b0};

    // Scan multiplier bit pairs: 01 adds, 10 subtracts the shifted multiplicand
    always_comb begin
        product = '0;
        for (int i = 0; i < OP_W; i++)
            product = ({q[i+1], q[i]} == 2'b01) ? product + (m_ext << i) :
                      ({q[i+1], q[i]} == 2'b10) ? product - (m_ext << i) : product;
    end

endmodule

// File: rtl/booth_mac.sv
// booth_mac: streaming signed dot-product of LEN Booth products with saturating accumulator
module booth_mac
    import booth_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 24,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [OP_W-1:0]          s1_a;
    logic [OP_W-1:0]          s1_b;
    logic                     s1_vld;
    logic [PROD_W-1:0]        product;
    logic signed [ACC_W-1:0]  acc;
    logic                     ovf;
    logic                     accept;
    logic                     last;
    logic                     clear;
    logic signed [ACC_W:0]    sum;
    logic signed [63:0]       sum_ext;
    logic signed [63:0]       sum_sat;
    logic                     clamp;

    assign accept = in_valid && in_ready;
    assign last   = cnt == CNT_W'(LEN - 1);
    assign clear  = (state == ST_HOLD) && out_ready;

    booth1 u_mul (
        .multiplier   (s1_a),
        .multiplicand (s1_b),
        .product      (product)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_ACCUM;
        else        state <= state_nxt;
    end

    // Next state: last accept drains one cycle, then hold until the result is taken
    always_comb begin
        state_nxt = (accept && last)     ? ST_DRAIN :
                    (state == ST_DRAIN)  ? ST_HOLD  :
                    clear                ? ST_ACCUM : state;
    end

    // Outputs decoded from registered state only; both handshakes are low during reset
    always_comb begin
        in_ready  = rst_n && (state == ST_ACCUM);
        out_valid = rst_n && (state == ST_HOLD);
        out_sum   = acc;
        out_ovf   = ovf;
    end

    // Products accepted in the current set
    always_ff @(posedge clk) begin
        if (!rst_n)      cnt <= '0;
        else if (accept) cnt <= last ? '0 : cnt + 1'b1;
    end

    // Operand register in front of the multiplier
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_a <= in_a;
                s1_b <= in_b;
            end
        end
    end

    // One-bit-wider sum so a single add can never wrap before clamping
    always_comb begin
        sum     = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){product[PROD_W-1]}}, product};
        sum_ext = {{(63-ACC_W){sum[ACC_W]}}, sum};
        sum_sat = sat(sum_ext, ACC_W);
        clamp   = sum_sat != sum_ext;
    end

    // Saturating accumulate with sticky overflow, cleared when the result is taken
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (s1_vld) begin
            acc <= sum_sat[ACC_W-1:0];
            ovf <= ovf | clamp;
        end
    end

endmodule

// File: tb/tb_booth_mac.sv
// tb_booth_mac: table-driven, random and corner-sequence checks of booth_mac at 24- and 16-bit widths
module tb_booth_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_ready;
    logic        in_ready, in_ready16;
    logic        out_valid, out_valid16;
    logic [23:0] sum24;
    logic [15:0] sum16;
    logic        ovf24, ovf16;

    int checks = 0;
    int errors = 0;

    booth_mac u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(sum24), .out_ovf(ovf24)
    );

    booth_mac #(.ACC_W(16)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid16), .out_ready(out_ready),
        .out_sum(sum16), .out_ovf(ovf16)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        int              gap;
        int              hold;
        int              e24;
        logic            o24;
        int              e16;
        logic            o16;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Saturating dot product computed straight from the arithmetic rules
    function automatic int model(input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                                 input int w, output logic o);
        int s, x, y, hi;
        s = 0;
        o = 1'b0;
        hi = (1 << (w - 1)) - 1;
        for (int i = 0; i < 4; i++) begin
            x = int'($signed(a[i]));
            y = int'($signed(b[i]));
            s = s + x * y;
            if (s > hi) begin s = hi; o = 1'b1; end
            else if (s < -hi - 1) begin s = -hi - 1; o = 1'b1; end
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one set of 4 pairs, then check latency, hold stability and the result
    task automatic do_set(input vec_t v, input string tag);
        logic [23:0] held;
        int t;
        for (int i = 0; i < 4; i++) begin
            t = 0;
            while (!in_ready && t < 20) begin tick(); t++; end
            chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            in_a = v.a[i];
            in_b = v.b[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            if (i < 3) for (int g = 0; g < v.gap; g++) tick();
        end
        chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_drain_ready"}, 32'(in_ready), 32'd0);
        tick();
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_out_valid16"}, 32'(out_valid16), 32'd1);
        held = sum24;
        for (int h = 0; h < v.hold; h++) begin
            tick();
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
            chk({tag, "_hold_stable"}, 32'(sum24), 32'(held));
        end
        chk({tag, "_sum24"}, 32'(sum24), 32'(v.e24) & 32'hffffff);
        chk({tag, "_ovf24"}, 32'(ovf24), 32'(v.o24));
        chk({tag, "_sum16"}, 32'(sum16), 32'(v.e16) & 32'hffff);
        chk({tag, "_ovf16"}, 32'(ovf16), 32'(v.o16));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_post_sum"}, 32'(sum24), 32'd0);
    endtask

    vec_t tbl[6];
    vec_t rv;
    int   sent, nres, lastc;

    initial begin
        tbl[0] = '{a: {8'd252, 8'd166, 8'h88, 8'd7}, b: {8'd255, 8'd201, 8'h54, 8'd6},
                   gap: 0, hold: 0, e24: -5084, o24: 1'b0, e16: -5084, o16: 1'b0};
        tbl[1] = '{a: {8'd252, 8'd166, 8'h88, 8'd7}, b: {8'd255, 8'd201, 8'h54, 8'd6},
                   gap: 1, hold: 5, e24: -5084, o24: 1'b0, e16: -5084, o16: 1'b0};
        tbl[2] = '{a: {4{8'h80}}, b: {4{8'h80}},
                   gap: 0, hold: 0, e24: 65536, o24: 1'b0, e16: 32767, o16: 1'b1};
        tbl[3] = '{a: {4{8'h01}}, b: {4{8'h01}},
                   gap: 0, hold: 1, e24: 4, o24: 1'b0, e16: 4, o16: 1'b0};
        tbl[4] = '{a: {4{8'h80}}, b: {4{8'h7f}},
                   gap: 2, hold: 0, e24: -65024, o24: 1'b0, e16: -32768, o16: 1'b1};
        tbl[5] = '{a: {8'h80, 8'h80, 8'h80, 8'h80}, b: {8'h7f, 8'h80, 8'h80, 8'h80},
                   gap: 0, hold: 2, e24: 32896, o24: 1'b0, e16: 16511, o16: 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_sum", 32'(sum24), 32'd0);
        chk("rel_ovf", 32'(ovf24), 32'd0);

        for (int i = 0; i < 6; i++) do_set(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a set discards the partial sum
        in_a = 8'd3;
        in_b = 8'd5;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum24), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("midrst_rel_ready", 32'(in_ready), 32'd1);
        rv = '{a: {4{8'd2}}, b: {4{8'd3}}, gap: 0, hold: 0, e24: 24, o24: 1'b0, e16: 24, o16: 1'b0};
        do_set(rv, "midrst");

        // Consumer always ready: results every LEN+2 cycles
        out_ready = 1'b1;
        sent = 0;
        nres = 0;
        lastc = -1;
        for (int c = 0; c < 60 && nres < 3; c++) begin
            if (out_valid) begin
                chk("b2b_sum", 32'(sum24), 32'd4);
                if (lastc >= 0) chk("b2b_gap", 32'(c - lastc), 32'd6);
                lastc = c;
                nres++;
            end
            in_a = 8'hff;
            in_b = 8'hff;
            in_valid = sent < 12;
            if (in_valid && in_ready) sent++;
            tick();
        end
        chk("b2b_count", 32'(nres), 32'd3);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_idle_ready", 32'(in_ready), 32'd1);

        // Random sets, biased toward extreme operands to exercise saturation
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 4; i++) begin
                rv.a[i] = ($urandom_range(0, 2) == 0) ? 8'h80 : 8'($urandom);
                rv.b[i] = ($urandom_range(0, 2) == 0) ? 8'h80 : 8'($urandom);
            end
            rv.gap = $urandom_range(0, 2);
            rv.hold = $urandom_range(0, 3);
            rv.e24 = model(rv.a, rv.b, 24, rv.o24);
            rv.e16 = model(rv.a, rv.b, 16, rv.o16);
            do_set(rv, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_mac.md
# booth_mac

Signed multiply-accumulate stage built around the existing 8-bit Booth multiplier (`booth1`). It accepts a stream of 8-bit operand pairs over a valid/ready handshake and registers each pair in front of `booth1`. It sums `LEN` consecutive 16-bit signed products into a saturating accumulator and presents each dot-product result on a valid/ready output port. It sits directly downstream of the operand source and consumes `booth1`'s `product`.

## Interface
- `LEN`, 4: products per result; must be ≥1.
- `ACC_W`, 24: accumulator/result width; must be ≥16.
- `CNT_W`, `$clog2(LEN+1)`: width of the product counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept a pair this cycle.
- `in_a`  in  8  multiplier, two's complement.
- `in_b`  in  8  multiplicand, two's complement.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  `ACC_W`  saturated signed sum of `LEN` products.
- `out_ovf`  out  1  saturation occurred at least once in this result.

## Operation
- **Accept:** a pair is accepted on an edge where `in_valid && in_ready`.
- **S1 register:**
  - An accepted pair loads `s1_a`/`s1_b` and sets `s1_vld`.
  - `s1_vld` clears on any edge with no accept.
  - `s1_a`/`s1_b` drive `booth1.multiplier`/`multiplicand`.
- **Accumulate:** on an edge with `s1_vld`=1, `acc <= sat(acc + sext(product))`.
  - The sum is computed at `ACC_W+1` bits.
  - Results above 2^(ACC_W-1)-1 clamp to that value; results below -2^(ACC_W-1) clamp to that value.
  - Any clamp sets sticky `ovf`.
- **FSM states:** ACCUM, DRAIN, HOLD.
  - ACCUM: `in_ready`=1. Each accept increments `cnt`. The accept that makes `cnt==LEN` moves to DRAIN and clears `cnt`.
  - DRAIN: `in_ready`=0. The last product is added on the next edge, then the FSM moves to HOLD.
  - HOLD: `in_ready`=0, `out_valid`=1. `out_sum`=`acc` and `out_ovf`=`ovf`, both held stable.
  - HOLD with `out_ready`=1: move to ACCUM, clear `acc` and `ovf`.
- **No input in ACCUM:** `in_valid`=0 in ACCUM stalls without side effects. The accumulator holds its value and `cnt` is unchanged.
- **Output back-pressure:** `out_ready` low in HOLD holds indefinitely. Input stays blocked.
- **Reset:** `rst_n`=0 on an edge forces the following, from any state and mid-sequence, discarding any partial sum:
  - state=ACCUM
  - `cnt`=0, `acc`=0, `ovf`=0
  - `s1_vld`=0, `s1_a`=`s1_b`=0
- **Outputs during reset:** while `rst_n`=0, `in_ready`=0 and `out_valid`=0.

## Timing
- **Reset values:**
  - `in_ready`=1 in the first cycle after reset deasserts; 0 while `rst_n`=0.
  - `out_valid`=0, `out_sum`=0, `out_ovf`=0.
- **Product latency:** a pair accepted at edge k is added to `acc` at edge k+1.
- **Result latency:** the `LEN`-th accept at edge n is followed by DRAIN in cycle n→n+1. `out_valid` is high from edge n+1.
- **Throughput:**
  - Best case: `LEN`+2 cycles per result (`LEN` accepts, DRAIN, one HOLD cycle with `out_ready`=1).
  - The first accept of the next set may occur on the edge after the HOLD handshake.
- **Handshake rules:**
  - `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from `in_valid` or `out_ready`.
  - The consumer may hold `out_ready`=1 continuously.
- **Saturation is per add:** after a clamp, later products of the same set may pull `acc` back inside range. `ovf` stays set.

## Structure
- **Package `booth_pkg`:**
  - `OP_W`=8 and `PROD_W`=16.
  - State encoding localparams `ST_ACCUM`=2'd0, `ST_DRAIN`=2'd1, `ST_HOLD`=2'd2.
  - A saturation helper function.
- **Sub-module:** exactly one, the existing `booth1`, instantiated unmodified between S1 and the accumulator.
- **Top level:** the FSM, counter and accumulator live in `booth_mac` itself.

## Test plan
- **Reset then single set:** reset, then `LEN`=4 pairs (7,6), (0x88,0x54), (166,201), (252,255) back-to-back.
  - Products are 42, -10080, 4950, 4.
  - Required: `out_sum`=-5084 (0xFFEC24 at 24 bits), `out_ovf`=0, `out_valid` one edge after the 4th accept.
- **Gapped input and output back-pressure:** same four pairs with `in_valid` low between each pair, and `out_ready` low for 5 cycles.
  - Required: same result held stable, `in_ready`=0 throughout HOLD, single result on `out_ready`.
- **Saturation:** `ACC_W`=16, four pairs (0x80,0x80) = +16384 each.
  - Required: `out_sum`=32767, `out_ovf`=1.
  - The next set, (1,1)×4, gives 4 with `out_ovf`=0.
- **Reset mid-operation:** accept 2 pairs, assert `rst_n`=0 for one edge, then send 4 pairs of (2,3).
  - Required: `out_sum`=24, with no contribution from the first two pairs.
- **Back-to-back results:** `out_ready` tied high, 3 sets of (-1,-1)×4.
  - Required: `out_sum`=4 each time, with results spaced exactly 6 cycles apart.
